cle_sram_arbiter: RTL and testbench

- Shares the single-port 1024x8 label SRAM between two requesters: port 0 (label writer) and port 1 (result reader / host readback).
- Uses a registered req/gnt handshake with burst hold and returns read data with fixed latency.
- Sits between the labeling engine and the SRAM macro, and owns the macro's A/D/WEN/CEN pins.

---
 rtl/cle_sram_arbiter.sv | 178 +++++++++++++++++
 tb/tb_cle_sram_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cle_sram_arbiter.sv
// cle_sram_arbiter
// Shares the single-port label SRAM between the label writer (port 0) and the
// result reader / host readback (port 1). Ownership is granted for a burst of
// accesses; while a port owns the macro, each cycle with its req high is one
// access driven straight onto the macro pins. Reads return one cycle later on
// rdata together with the owner's rvalid.
//
// Build option: define CLE_ARB_ROUND_ROBIN_EN to arbitrate ties round-robin
// instead of the default fixed priority (port 0 over port 1).

module cle_sram_arbiter #(
  parameter int AW        = 10,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          p0_req,
  input  logic          p0_wen,
  input  logic [AW-1:0] p0_a,
  input  logic [DW-1:0] p0_d,
  input  logic          p0_last,
  output logic          p0_gnt,
  output logic          p0_rvalid,

  input  logic          p1_req,
  input  logic          p1_wen,
  input  logic [AW-1:0] p1_a,
  input  logic [DW-1:0] p1_d,
  input  logic          p1_last,
  output logic          p1_gnt,
  output logic          p1_rvalid,

  output logic [DW-1:0] rdata,
  input  logic [DW-1:0] sram_q,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_d,
  output logic          sram_wen,
  output logic          sram_cen,

  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  // The burst counter is 8 bits wide, so the limit is held at the same width.
  localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] burst_cnt;
  logic [7:0] burst_cnt_nxt;
  logic [7:0] burst_cnt_inc;

  logic       acc0;
  logic       acc1;
  logic       own_req;
  logic       own_last;
  logic       any_req;
  logic       pick1;

  logic       rvalid0_q;
  logic       rvalid1_q;

  // Grants are a decode of the registered state, so they change only on edges.
  assign p0_gnt = (state == OWN0);
  assign p1_gnt = (state == OWN1);

  // An access is accepted whenever the owner presents req while holding gnt.
  assign acc0 = p0_gnt & p0_req;
  assign acc1 = p1_gnt & p1_req;

  // Request and last flag of whichever port currently owns the macro.
  assign own_req  = (state == OWN1) ? p1_req  : p0_req;
  assign own_last = (state == OWN1) ? p1_last : p0_last;

  assign any_req       = p0_req | p1_req;
  assign burst_cnt_inc = burst_cnt + 8'd1;

`ifdef CLE_ARB_ROUND_ROBIN_EN
  logic last_owner;

  // On a tie, the port that was not granted most recently wins.
  assign pick1 = p1_req & (~p0_req | ~last_owner);

  // Remember the most recent winner each time the arbiter leaves IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner <= 1'b1;
    end else if ((state == IDLE) && any_req) begin
      last_owner <= pick1;
    end
  end
`else
  // Fixed priority: port 1 only wins when port 0 is not asking.
  assign pick1 = p1_req & ~p0_req;
`endif

  // State and burst-count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      burst_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Next-state logic: grant from IDLE, release on req drop, last or burst limit.
  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt     = pick1 ? OWN1 : OWN0;
          burst_cnt_nxt = 8'd0;
        end
      end
      OWN0, OWN1: begin
        if (!own_req) begin
          state_nxt = IDLE;
        end else begin
          burst_cnt_nxt = burst_cnt_inc;
          if (own_last || (burst_cnt_inc == BURST_LIMIT)) begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt     = IDLE;
        burst_cnt_nxt = 8'd0;
      end
    endcase
  end

  // Macro pins follow the owner's access; otherwise the macro is disabled.
  always_comb begin
    sram_a   = '0;
    sram_d   = '0;
    sram_wen = 1'b1;
    sram_cen = 1'b1;
    if (acc0) begin
      sram_a   = p0_a;
      sram_d   = p0_d;
      sram_wen = p0_wen;
      sram_cen = 1'b0;
    end else if (acc1) begin
      sram_a   = p1_a;
      sram_d   = p1_d;
      sram_wen = p1_wen;
      sram_cen = 1'b0;
    end
  end

  // Read-return flags: a read accepted this cycle has data on the next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      rvalid0_q <= acc0 & p0_wen;
      rvalid1_q <= acc1 & p1_wen;
    end
  end

  assign p0_rvalid = rvalid0_q;
  assign p1_rvalid = rvalid1_q;
  assign rdata     = sram_q;
  assign busy      = (state != IDLE) | rvalid0_q | rvalid1_q;

endmodule

// File: tb/tb_cle_sram_arbiter.sv
// tb_cle_sram_arbiter
// Bench for cle_sram_arbiter with a behavioural 1024x8 SRAM macro attached.
// Expected read data is queued when a read is accepted and compared when the
// owning port's rvalid fires. Honours CLE_ARB_ROUND_ROBIN_EN for tie order.

module tb_cle_sram_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic          p0_req, p0_wen, p0_last;
  logic [AW-1:0] p0_a;
  logic [DW-1:0] p0_d;
  logic          p0_gnt, p0_rvalid;
  logic          p1_req, p1_wen, p1_last;
  logic [AW-1:0] p1_a;
  logic [DW-1:0] p1_d;
  logic          p1_gnt, p1_rvalid;
  logic [DW-1:0] rdata;
  logic [DW-1:0] sram_q;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic          sram_wen, sram_cen;
  logic          busy;

  cle_sram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(16)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_wen(p0_wen), .p0_a(p0_a), .p0_d(p0_d), .p0_last(p0_last),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_wen(p1_wen), .p1_a(p1_a), .p1_d(p1_d), .p1_last(p1_last),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .rdata(rdata), .sram_q(sram_q), .sram_a(sram_a), .sram_d(sram_d),
    .sram_wen(sram_wen), .sram_cen(sram_cen), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port macro: captures on the rising edge when enabled.
  logic [DW-1:0] mem [0:1023];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_wen) mem[sram_a] <= sram_d;
      else           sram_q      <= mem[sram_a];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          port;
    logic [7:0]  data;
    int          cyc;
  } rd_exp_t;

  rd_exp_t sb_q[$];

  int vec_cnt    = 0;
  int miss_cnt   = 0;
  int wr_strobes = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_cnt++;
    if (actual !== expected) begin
      miss_cnt++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Pin, exclusivity and read-return monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (p0_gnt && p0_req)
      checkOutput("pins_p0", 32'({sram_cen, sram_wen, sram_a, sram_d}), 32'({1'b0, p0_wen, p0_a, p0_d}));
    else if (p1_gnt && p1_req)
      checkOutput("pins_p1", 32'({sram_cen, sram_wen, sram_a, sram_d}), 32'({1'b0, p1_wen, p1_a, p1_d}));
    else
      checkOutput("pins_idle", 32'({sram_cen, sram_wen}), 32'h3);
    checkOutput("gnt_exclusive", 32'(p0_gnt & p1_gnt), 32'h0);
    if (!sram_cen && !sram_wen) wr_strobes++;

    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      vec_cnt++;
      miss_cnt++;
      $display("[TB] FAIL rvalid_overdue: read due cycle %0d not returned by cycle %0d", sb_q[0].cyc, cyc);
      void'(sb_q.pop_front());
    end
    if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      checkOutput("rvalid_port", 32'({p1_rvalid, p0_rvalid}), sb_q[0].port ? 32'h2 : 32'h1);
      checkOutput("rdata", 32'(rdata), 32'(sb_q[0].data));
      void'(sb_q.pop_front());
    end else begin
      checkOutput("no_spurious_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'h0);
    end
  end

  // One access on a port: present it, wait for grant, queue read data, advance.
  task automatic applyStimulus(input bit port, input bit wen, input logic [9:0] a,
                               input logic [7:0] d, input bit last, input logic [7:0] exp_data,
                               input bit keep_req, output int waited);
    waited = -1;
    if (!port) begin
      p0_req = 1'b1; p0_wen = wen; p0_a = a; p0_d = d; p0_last = last;
    end else begin
      p1_req = 1'b1; p1_wen = wen; p1_a = a; p1_d = d; p1_last = last;
    end
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if ((!port && p0_gnt) || (port && p1_gnt)) begin
        waited = k;
        break;
      end
      @(posedge clk); #1;
    end
    if (waited < 0) begin
      vec_cnt++;
      miss_cnt++;
      $display("[TB] FAIL grant_timeout: port %0d got no grant within 64 cycles", port);
    end else if (wen) begin
      sb_q.push_back('{port: port, data: exp_data, cyc: cyc + 1});
    end
    @(posedge clk); #1;
    if (!keep_req) begin
      if (!port) begin p0_req = 1'b0; p0_last = 1'b0; end
      else       begin p1_req = 1'b0; p1_last = 1'b0; end
    end
  endtask

  typedef struct {
    bit         port;
    bit         wen;
    logic [9:0] a;
    logic [7:0] d;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[7];
  int   exp_order[4];

  initial begin
    int waited;
    int found;
    int wr_base;
    logic [7:0] sdata;

    reset = 1'b1;
    p0_req = 0; p0_wen = 1; p0_a = '0; p0_d = '0; p0_last = 0;
    p1_req = 0; p1_wen = 1; p1_a = '0; p1_d = '0; p1_last = 0;

    tbl[0] = '{port: 1'b0, wen: 1'b0, a: 10'h005, d: 8'h03, exp_data: 8'h00};
    tbl[1] = '{port: 1'b1, wen: 1'b1, a: 10'h005, d: 8'h00, exp_data: 8'h03};
    tbl[2] = '{port: 1'b1, wen: 1'b0, a: 10'h3FF, d: 8'hA5, exp_data: 8'h00};
    tbl[3] = '{port: 1'b0, wen: 1'b1, a: 10'h3FF, d: 8'h00, exp_data: 8'hA5};
    tbl[4] = '{port: 1'b0, wen: 1'b0, a: 10'h000, d: 8'hFF, exp_data: 8'h00};
    tbl[5] = '{port: 1'b0, wen: 1'b1, a: 10'h000, d: 8'h00, exp_data: 8'hFF};
    tbl[6] = '{port: 1'b1, wen: 1'b1, a: 10'h005, d: 8'h00, exp_data: 8'h03};

`ifdef CLE_ARB_ROUND_ROBIN_EN
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
`else
    exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 0; exp_order[3] = 0;
`endif

    // Reset values
    @(negedge clk);
    checkOutput("rst_gnt",    32'({p1_gnt, p0_gnt}), 32'h0);
    checkOutput("rst_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'h0);
    checkOutput("rst_busy",   32'(busy), 32'h0);
    checkOutput("rst_pins",   32'({sram_cen, sram_wen, sram_a, sram_d}), 32'({2'b11, 10'h0, 8'h0}));
    @(posedge clk); #1;
    reset = 1'b0;

    // Single accesses with last=1: 1-cycle grant latency, release, busy in release cycle
    for (int i = 0; i < 7; i++) begin
      applyStimulus(tbl[i].port, tbl[i].wen, tbl[i].a, tbl[i].d, 1'b1, tbl[i].exp_data, 1'b0, waited);
      checkOutput("tbl_gnt_latency", 32'(waited), 32'd1);
      @(negedge clk);
      checkOutput("tbl_gnt_release", 32'({p1_gnt, p0_gnt}), 32'h0);
      checkOutput("tbl_busy_turnaround", 32'(busy), 32'(tbl[i].wen));
      @(posedge clk); #1;
    end

    // Simultaneous requests: port 0 first, port 1 after one turnaround cycle
    p0_req = 1; p0_wen = 0; p0_a = 10'h010; p0_d = 8'h11; p0_last = 1;
    p1_req = 1; p1_wen = 0; p1_a = 10'h011; p1_d = 8'h22; p1_last = 1;
    @(negedge clk);
    checkOutput("tie_idle", 32'({p1_gnt, p0_gnt}), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("tie_p0_first", 32'({p1_gnt, p0_gnt}), 32'h1);
    @(posedge clk); #1;
    p0_req = 0;
    @(negedge clk);
    checkOutput("tie_turnaround", 32'({p1_gnt, p0_gnt}), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("tie_p1_second", 32'({p1_gnt, p0_gnt}), 32'h2);
    @(posedge clk); #1;
    p1_req = 0;
    @(negedge clk);
    checkOutput("tie_released", 32'({p1_gnt, p0_gnt}), 32'h0);
    @(posedge clk); #1;

    // Back-to-back contention: grant order depends on arbitration mode
    p0_req = 1; p0_wen = 0; p0_a = 10'h020; p0_d = 8'h33; p0_last = 1;
    p1_req = 1; p1_wen = 0; p1_a = 10'h021; p1_d = 8'h44; p1_last = 1;
    for (int g = 0; g < 4; g++) begin
      found = -1;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (p0_gnt) begin found = 0; break; end
        if (p1_gnt) begin found = 1; break; end
        @(posedge clk); #1;
      end
      checkOutput("contention_order", 32'(found), 32'(exp_order[g]));
      @(posedge clk); #1;
    end
    p0_req = 0; p0_last = 0;
    p1_req = 0; p1_last = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the cycle after a port 1 read is accepted
    applyStimulus(1'b1, 1'b1, 10'h005, 8'h00, 1'b0, 8'h03, 1'b1, waited);
    reset = 1'b1;
    sb_q.delete();
    @(negedge clk);
    checkOutput("rst_mid_gnt",    32'(p1_gnt), 32'h0);
    checkOutput("rst_mid_rvalid", 32'(p1_rvalid), 32'h0);
    checkOutput("rst_mid_cen",    32'(sram_cen), 32'h1);
    checkOutput("rst_mid_busy",   32'(busy), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    p1_req = 0;
    @(negedge clk);
    checkOutput("post_rst_idle", 32'({p1_gnt, p0_gnt, busy}), 32'h0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 10'h030, 8'h77, 1'b1, 8'h00, 1'b0, waited);
    checkOutput("post_rst_latency", 32'(waited), 32'd1);
    applyStimulus(1'b1, 1'b1, 10'h030, 8'h00, 1'b1, 8'h77, 1'b0, waited);

    // 40-write stream without last: forced releases after accesses 16 and 32
    wr_base = wr_strobes;
    for (int i = 0; i < 40; i++) begin
      sdata = 8'(i * 7 + 1);
      applyStimulus(1'b0, 1'b0, 10'(10'h100 + i), sdata, 1'b0, 8'h00, 1'b1, waited);
      checkOutput("stream_regrant_gap", 32'(waited), (i % 16 == 0) ? 32'd1 : 32'd0);
    end
    p0_req = 0;
    checkOutput("stream_write_count", 32'(wr_strobes - wr_base), 32'd40);
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      sdata = 8'(i * 7 + 1);
      applyStimulus(1'b1, 1'b1, 10'(10'h100 + i), 8'h00, (i == 39), sdata, 1'b1, waited);
    end
    p1_req = 0; p1_last = 0;
    @(posedge clk); #1;

    // Idle port toggles its inputs while port 0 owns the macro
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        p1_req = (i == 5) ? 1'b0 : 1'($urandom_range(0, 1));
        p1_wen = 1'($urandom_range(0, 1));
        p1_a   = 10'($urandom_range(0, 1023));
        p1_d   = 8'($urandom_range(0, 255));
      end
      applyStimulus(1'b0, 1'(i % 2), 10'(10'h200 + i / 2), 8'(8'h40 + i), (i == 5),
                    8'(8'h40 + i - 1), 1'b1, waited);
      checkOutput("toggle_hold", 32'(waited), (i == 0) ? 32'd1 : 32'd0);
    end
    p0_req = 0; p0_last = 0;

    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    checkOutput("final_busy", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
